m_axi_lite: RTL
===============

# m_axi_lite

AXI4-Lite master (initiator) that converts single-beat read/write commands from local logic into AXI4-Lite transactions. It is the counterpart of the AXI4-Lite slave register block and drives its AW/W/B/AR/R channels directly. Exactly one transaction is in flight at a time. Each completion is returned to the local side on a registered response port.

## Interface
- P_M_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- P_M_AXI_ADDR_WIDTH, 4, AXI address width.
- M_AXI_ACLK  in  1  clock; all logic on the rising edge.
- M_AXI_ARESET  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR  transaction address.
- cmd_wdata  in  DATA  write data.
- cmd_wstrb  in  DATA/8  write strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when high with rsp_valid.
- rsp_we  out  1  echo of cmd_we for this response.
- rsp_rdata  out  DATA  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP as received.
- err_cnt  out  16  count of non-OKAY responses; present only with the macro (see Configuration).
- M_AXI_AWADDR/AWPROT/AWVALID/AWREADY, WDATA/WSTRB/WVALID/WREADY, BRESP/BVALID/BREADY, ARADDR/ARPROT/ARVALID/ARREADY, RDATA/RRESP/RVALID/RREADY: standard AXI4-Lite master ports. Widths follow the parameters. PROT is 3 bits.

## Operation
- States: IDLE, WRITE, WRESP, READ_A, READ_D, RESP.
- IDLE:
  - cmd_ready = 1 (combinational: state == IDLE and reset low).
  - On accept, the command is registered.
  - cmd_we = 1: go to WRITE with AWVALID = WVALID = 1.
  - cmd_we = 0: go to READ_A with ARVALID = 1.
- WRITE:
  - AW and W complete independently. Each VALID drops on the edge after its own handshake.
  - AWADDR, WDATA and WSTRB stay stable while the matching VALID is high.
  - Go to WRESP on the edge where both handshakes are complete. This includes both completing in the same cycle.
- WRESP:
  - BREADY = 1.
  - On BVALID, capture BRESP and go to RESP with rsp_valid = 1 and rsp_rdata = 0.
- READ_A:
  - ARVALID is held until ARREADY, then go to READ_D.
- READ_D:
  - RREADY = 1.
  - On RVALID, capture RDATA and RRESP and go to RESP.
- RESP:
  - rsp_* outputs hold until rsp_ready; then return to IDLE.
  - A new command can be accepted no earlier than the cycle after the response handshake.
- AWPROT and ARPROT are constant 3'b000.
- BREADY and RREADY are never high outside WRESP and READ_D.
- Non-OKAY responses are passed through unchanged. No retry.

## Timing
- Reset values:
  - every VALID/READY output = 0 and rsp_valid = 0;
  - all address, data, strobe, resp and err_cnt outputs = 0;
  - state = IDLE.
- cmd_ready reads 0 while reset is asserted.
- Best-case write (slave ready immediately): cmd accepted at cycle 0; AW/W valid at cycle 1; BREADY at cycle 2; rsp_valid at cycle 3.
- Best-case read: same profile (ARVALID cycle 1, RREADY cycle 2, rsp_valid cycle 3).
- No combinational path from any AXI input to any AXI output. All AXI outputs are registered.
- VALID, once asserted, is never withdrawn before its handshake, even while the slave stalls indefinitely.
- Reset mid-transaction: all outputs return to their reset values on the next edge and the transaction is abandoned. No response is produced.
- cmd inputs are ignored outside IDLE.

## Configuration
- M_AXI_LITE_ERRCNT_EN defined:
  - err_cnt increments by 1 on each B or R handshake whose resp is not 2'b00.
  - It saturates at 16'hFFFF and clears only on reset.
- Not defined: the err_cnt port and its counter are absent. All other behaviour is identical.

## Test plan
- Write cmd, addr 0x4, data 0xDEADBEEF, strb 0xF, slave ready immediately -> AWADDR = 0x4 and WDATA = 0xDEADBEEF at cycle 1; rsp_valid at cycle 3 with rsp_we = 1 and rsp_resp = 0.
- Slave holds WREADY low for 5 cycles but asserts AWREADY at once -> AWVALID drops after 1 cycle; WVALID stays high with stable data until WREADY; BREADY only after both handshakes.
- Read cmd, addr 0x8, slave returns 0x12345678 after 3 cycles of RVALID delay -> rsp_rdata = 0x12345678 and rsp_resp = 0; RREADY is high only in READ_D.
- rsp_ready held low for 10 cycles -> rsp_* stable; cmd_ready = 0 throughout; the next cmd is accepted only after the response handshake.
- Slave returns BRESP = 2'b10 twice (macro defined) -> rsp_resp = 2'b10 each time and err_cnt = 2. With the macro undefined, the build has no err_cnt port.
- Assert M_AXI_ARESET while in WRITE with WVALID pending -> next cycle all valids are 0, state is IDLE, no rsp_valid, and cmd_ready = 1 once reset deasserts.

Source files
------------

// File: rtl/m_axi_lite_if.sv
// AXI4-Lite channel bundle (AW/W/B/AR/R) shared by m_axi_lite and its slave counterpart.
interface m_axi_lite_if #(
  parameter int unsigned P_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned P_M_AXI_ADDR_WIDTH = 4
);
  logic [P_M_AXI_ADDR_WIDTH-1:0]   AWADDR;
  logic [2:0]                      AWPROT;
  logic                            AWVALID;
  logic                            AWREADY;
  logic [P_M_AXI_DATA_WIDTH-1:0]   WDATA;
  logic [P_M_AXI_DATA_WIDTH/8-1:0] WSTRB;
  logic                            WVALID;
  logic                            WREADY;
  logic [1:0]                      BRESP;
  logic                            BVALID;
  logic                            BREADY;
  logic [P_M_AXI_ADDR_WIDTH-1:0]   ARADDR;
  logic [2:0]                      ARPROT;
  logic                            ARVALID;
  logic                            ARREADY;
  logic [P_M_AXI_DATA_WIDTH-1:0]   RDATA;
  logic [1:0]                      RRESP;
  logic                            RVALID;
  logic                            RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WVALID,
    input  WREADY,
    input  BRESP, BVALID,
    output BREADY,
    output ARADDR, ARPROT, ARVALID,
    input  ARREADY,
    input  RDATA, RRESP, RVALID,
    output RREADY
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WVALID,
    output WREADY,
    output BRESP, BVALID,
    input  BREADY,
    input  ARADDR, ARPROT, ARVALID,
    output ARREADY,
    output RDATA, RRESP, RVALID,
    input  RREADY
  );
endinterface

// File: rtl/m_axi_lite.sv
// Single-outstanding AXI4-Lite master: local cmd/rsp port to AW/W/B/AR/R channels.
// Optional non-OKAY response counter (err_cnt port) enabled by `define M_AXI_LITE_ERRCNT_EN.
module m_axi_lite #(
  parameter int unsigned P_M_AXI_DATA_WIDTH = 32,
  parameter int unsigned P_M_AXI_ADDR_WIDTH = 4
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESET,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_we,
  input  logic [P_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [P_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [P_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_we,
  output logic [P_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
`ifdef M_AXI_LITE_ERRCNT_EN
  output logic [15:0]                     err_cnt,
`endif
  m_axi_lite_if.master                    m_axi
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WRITE  = 3'd1;
  localparam logic [2:0] ST_WRESP  = 3'd2;
  localparam logic [2:0] ST_READ_A = 3'd3;
  localparam logic [2:0] ST_READ_D = 3'd4;
  localparam logic [2:0] ST_RESP   = 3'd5;

  logic [2:0]                      state;
  logic [P_M_AXI_ADDR_WIDTH-1:0]   awaddr_q;
  logic                            awvalid_q;
  logic [P_M_AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [P_M_AXI_DATA_WIDTH/8-1:0] wstrb_q;
  logic                            wvalid_q;
  logic                            bready_q;
  logic [P_M_AXI_ADDR_WIDTH-1:0]   araddr_q;
  logic                            arvalid_q;
  logic                            rready_q;
  logic                            aw_clear;
  logic                            w_clear;

  assign m_axi.AWADDR  = awaddr_q;
  assign m_axi.AWPROT  = '0;
  assign m_axi.AWVALID = awvalid_q;
  assign m_axi.WDATA   = wdata_q;
  assign m_axi.WSTRB   = wstrb_q;
  assign m_axi.WVALID  = wvalid_q;
  assign m_axi.BREADY  = bready_q;
  assign m_axi.ARADDR  = araddr_q;
  assign m_axi.ARPROT  = '0;
  assign m_axi.ARVALID = arvalid_q;
  assign m_axi.RREADY  = rready_q;

  // A channel counts as done once its VALID has dropped or is handshaking this cycle.
  always_comb begin
    aw_clear  = ~awvalid_q | m_axi.AWREADY;
    w_clear   = ~wvalid_q  | m_axi.WREADY;
    cmd_ready = (state == ST_IDLE) && !M_AXI_ARESET;
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state     <= ST_IDLE;
      awaddr_q  <= '0;
      awvalid_q <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_we    <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (cmd_we) begin
              awaddr_q  <= cmd_addr;
              wdata_q   <= cmd_wdata;
              wstrb_q   <= cmd_wstrb;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state     <= ST_WRITE;
            end else begin
              araddr_q  <= cmd_addr;
              arvalid_q <= 1'b1;
              state     <= ST_READ_A;
            end
          end
        end
        ST_WRITE: begin
          if (awvalid_q && m_axi.AWREADY) awvalid_q <= 1'b0;
          if (wvalid_q && m_axi.WREADY)   wvalid_q  <= 1'b0;
          if (aw_clear && w_clear) begin
            bready_q <= 1'b1;
            state    <= ST_WRESP;
          end
        end
        ST_WRESP: begin
          if (m_axi.BVALID) begin
            bready_q  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_we    <= 1'b1;
            rsp_rdata <= '0;
            rsp_resp  <= m_axi.BRESP;
            state     <= ST_RESP;
          end
        end
        ST_READ_A: begin
          if (m_axi.ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state     <= ST_READ_D;
          end
        end
        ST_READ_D: begin
          if (m_axi.RVALID) begin
            rready_q  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_we    <= 1'b0;
            rsp_rdata <= m_axi.RDATA;
            rsp_resp  <= m_axi.RRESP;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef M_AXI_LITE_ERRCNT_EN
  logic resp_err;

  always_comb begin
    resp_err = (bready_q && m_axi.BVALID && (m_axi.BRESP != 2'b00)) ||
               (rready_q && m_axi.RVALID && (m_axi.RRESP != 2'b00));
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      err_cnt <= '0;
    end else if (resp_err && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule
